hook_launcher: RTL and testbench
================================

# hook_launcher

Rope-launch controller that sits directly downstream of the swinging hook pendulum. It takes the pendulum tip position, a fire button and collision information from the object layer, and produces the live rope-tip position for the drawing and collision logic. It gates the pendulum's `enable`, so swinging freezes while the rope is out. It extends the rope along the frozen swing direction, reels it back at a weight-dependent speed, and pulses a catch report to the scoring logic.

## Interface
- `ANCHOR_X`, 320, pivot x; must equal the pendulum's pivot x
- `ANCHOR_Y`, 96, pivot y; must equal the pendulum's pivot y
- `BASE_SHIFT`, 7, log2 of the pendulum's arm length; the pendulum is instantiated with `LENGTH = 2**BASE_SHIFT` (128)
- `MAX_LEN`, 400, maximum rope length in pixels
- `EXTEND_STEP`, 4, pixels added per frame while extending
- `RETRACT_STEP`, 8, base pixels removed per frame while retracting
- `SCREEN_W`, 640; `SCREEN_H`, 480, visible area

Ports:
- `clk`  in  1  system clock
- `resetN`  in  1  asynchronous, active-low reset
- `startOfFrame`  in  1  one-cycle pulse per video frame
- `fire`  in  1  level from key debouncer
- `hookX`, `hookY`  in  11  pendulum tip position (unsigned)
- `grab`  in  1  rope-tip/gold collision, any cycle
- `grabWeight`  in  2  weight class of the colliding object
- `hookEnable`  out  1  drives the pendulum `enable`
- `tipX`, `tipY`  out  11  current rope-tip position, registered
- `ropeLen`  out  10  current rope length
- `busy`  out  1  high when not IDLE
- `caught`  out  1  one-cycle catch pulse
- `caughtWeight`  out  2  weight of the caught object; valid with `caught`

## Operation
States: IDLE, EXTEND, RETRACT, DELIVER.

- **IDLE**
  - `hookEnable=1`, `ropeLen=128`.
  - `tipX/tipY` register `hookX/hookY` every cycle.
  - Rising edge of `fire` (edge detected against the previous sampled value) latches the direction: `dx = hookX - ANCHOR_X` and `dy = hookY - ANCHOR_Y`, both signed 12 bit.
  - Then go to EXTEND.
- **EXTEND**
  - On each `startOfFrame`: `nextLen = ropeLen + EXTEND_STEP`.
  - Candidate tip = `ANCHOR + ((d * nextLen) >>> BASE_SHIFT)`, with a signed 23-bit product and an arithmetic shift.
  - Out of bounds or `nextLen > MAX_LEN` (x<0, x≥SCREEN_W, y<0 or y≥SCREEN_H): `ropeLen` unchanged, `hit=0`, go to RETRACT.
  - Otherwise `ropeLen` takes `nextLen`.
  - `grab=1` in any EXTEND cycle latches `hit=1` and `weight=grabWeight`, and goes to RETRACT on the next cycle.
  - Grab has priority over a boundary or max-length stop in the same cycle.
- **RETRACT**
  - On each `startOfFrame`: `step = RETRACT_STEP >> (hit ? weight : 0)`, minimum 1.
  - If `ropeLen - step ≤ 128`: set `ropeLen=128` and go to DELIVER.
  - Otherwise subtract `step`.
  - `grab` is ignored.
- **DELIVER**
  - One cycle; `caught = hit`, `caughtWeight = weight`.
  - Then go to IDLE and clear `hit`.
- **Tip outside IDLE:** `tipX/tipY` are recomputed from the latched `d` and `ropeLen`.
- **`fire` outside IDLE** is ignored. A `fire` held high through return to IDLE does not relaunch; a new rising edge is required.
- **`hookEnable`** = (state==IDLE). `busy` = !IDLE.

## Timing
- **Reset values:**
  - State IDLE, `ropeLen=128`, `tipX=320`, `tipY=224`.
  - `hookEnable=1`, `busy=0`, `caught=0`, `caughtWeight=0`.
  - `dx=0`, `dy=128`, `hit=0`, fire history 0.
  - A reset in any state returns to IDLE immediately; no `caught` pulse is produced.
- **Fire edge → EXTEND:** 1 cycle. `hookEnable` falls in that same cycle, so the pendulum freezes before its next frame update.
- **Length change:** only on `startOfFrame` cycles. `tipX/tipY` update 1 cycle after the `ropeLen` change.
- **`grab` → RETRACT:** 1 cycle, independent of frame timing.
- **`caught`:** exactly 1 cycle, then IDLE on the next cycle.

## Test plan
- **Reset:** assert `resetN=0` → outputs equal the reset values; IDLE tracks `hookX=300,hookY=200` → `tipX=300,tipY=200` one cycle later.
- **Straight-down launch and miss:** `hookX=320,hookY=224`, pulse `fire`, no grab.
  - Extend: `ropeLen` goes 132, 136, … up to 380 (frame 63). Frame 64 candidate y=480 is out of bounds → RETRACT with `ropeLen=380`.
  - Retract: step 8 per frame; after 31 retract frames `ropeLen` reaches 132. The next frame clamps to 128 → DELIVER with `caught=0`.
- **Diagonal geometry:** `hookX=411,hookY=187`, fire, wait 32 frames (`ropeLen=256`) → `tipX=502`, `tipY=278`.
- **Weighted catch:** straight down, `grab=1` with `grabWeight=2` when `ropeLen=168`.
  - → RETRACT next cycle; step 2; 20 frames to 128.
  - → `caught=1` for one cycle with `caughtWeight=2`, then IDLE with `hookEnable=1`.
- **Simultaneous events:** `grab=1` in the same frame that the max/boundary condition triggers → `hit=1`, catch reported.
- **Simultaneous events:** `fire` toggling during EXTEND/RETRACT → no effect.
- **Reset mid-operation:** `resetN` low during RETRACT → IDLE and `ropeLen=128` immediately, no `caught` pulse.

Source files
------------

// File: rtl/hook_launcher.sv
`default_nettype none
// ============================================================================
// Module   : hook_launcher
// Purpose  : Rope-launch controller that freezes the pendulum and drives the rope tip
// Revision : 1.0  initial release
// ============================================================================
module hook_launcher #(
  parameter int ANCHOR_X     = 320,
  parameter int ANCHOR_Y     = 96,
  parameter int BASE_SHIFT   = 7,
  parameter int MAX_LEN      = 400,
  parameter int EXTEND_STEP  = 4,
  parameter int RETRACT_STEP = 8,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] hookX,
  input  logic [10:0] hookY,
  input  logic        grab,
  input  logic [1:0]  grabWeight,
  output logic        hookEnable,
  output logic [10:0] tipX,
  output logic [10:0] tipY,
  output logic [9:0]  ropeLen,
  output logic        busy,
  output logic        caught,
  output logic [1:0]  caughtWeight
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_EXTEND  = 2'd1;
  localparam logic [1:0] c_RETRACT = 2'd2;
  localparam logic [1:0] c_DELIVER = 2'd3;

  localparam logic [9:0]         c_BASE_LEN = 10'(2**BASE_SHIFT);
  localparam logic signed [16:0] c_ANCHOR_X = 17'(ANCHOR_X);
  localparam logic signed [16:0] c_ANCHOR_Y = 17'(ANCHOR_Y);
  localparam logic signed [16:0] c_SCREEN_W = 17'(SCREEN_W);
  localparam logic signed [16:0] c_SCREEN_H = 17'(SCREEN_H);
  localparam logic signed [11:0] c_RST_DX   = 12'sd0;
  localparam logic signed [11:0] c_RST_DY   = 12'(2**BASE_SHIFT);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic signed [11:0] r_dx;
  logic signed [11:0] r_dy;
  logic [9:0]         r_len;
  logic [10:0]        r_tip_x;
  logic [10:0]        r_tip_y;
  logic               r_hit;
  logic [1:0]         r_weight;
  logic               r_fire_d;

  logic               w_fire_rise;
  logic [10:0]        w_next_len;
  logic signed [16:0] w_cand_x;
  logic signed [16:0] w_cand_y;
  logic               w_stop;
  logic [9:0]         w_step;
  logic               w_done;

  // Tip = anchor + (d * len) / 2**BASE_SHIFT, floor division on the signed product
  function automatic logic signed [16:0] f_project(
    input logic signed [11:0] d,
    input logic [9:0]         len,
    input logic signed [16:0] anchor
  );
    logic signed [22:0] prod;
    prod = 23'(d) * 23'($signed({1'b0, len}));
    return 17'(prod >>> BASE_SHIFT) + anchor;
  endfunction

  assign w_fire_rise = fire & ~r_fire_d;
  assign w_next_len  = {1'b0, r_len} + 11'(EXTEND_STEP);
  assign w_cand_x    = f_project(r_dx, w_next_len[9:0], c_ANCHOR_X);
  assign w_cand_y    = f_project(r_dy, w_next_len[9:0], c_ANCHOR_Y);
  assign w_stop      = (w_cand_x < 17'sd0) || (w_cand_x >= c_SCREEN_W) ||
                       (w_cand_y < 17'sd0) || (w_cand_y >= c_SCREEN_H) ||
                       (w_next_len > 11'(MAX_LEN));

  // Heavier catches reel in slower; never let the step collapse to zero
  always_comb begin
    w_step = 10'(RETRACT_STEP) >> (r_hit ? r_weight : 2'd0);
    if (w_step == 10'd0) begin
      w_step = 10'd1;
    end
  end

  assign w_done = {1'b0, r_len} <= ({1'b0, c_BASE_LEN} + {1'b0, w_step});

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_fire_rise) w_next_state = c_EXTEND;
      end
      c_EXTEND: begin
        if (grab || (startOfFrame && w_stop)) w_next_state = c_RETRACT;
      end
      c_RETRACT: begin
        if (startOfFrame && w_done) w_next_state = c_DELIVER;
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  always_comb begin
    hookEnable   = (r_state == c_IDLE);
    busy         = (r_state != c_IDLE);
    caught       = (r_state == c_DELIVER) && r_hit;
    caughtWeight = ((r_state == c_DELIVER) && r_hit) ? r_weight : 2'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_dx     <= c_RST_DX;
      r_dy     <= c_RST_DY;
      r_len    <= c_BASE_LEN;
      r_tip_x  <= 11'(ANCHOR_X);
      r_tip_y  <= 11'(ANCHOR_Y + 2**BASE_SHIFT);
      r_hit    <= 1'b0;
      r_weight <= 2'd0;
      r_fire_d <= 1'b0;
    end else begin
      r_fire_d <= fire;
      if (r_state == c_IDLE) begin
        r_tip_x <= hookX;
        r_tip_y <= hookY;
      end else begin
        r_tip_x <= 11'(f_project(r_dx, r_len, c_ANCHOR_X));
        r_tip_y <= 11'(f_project(r_dy, r_len, c_ANCHOR_Y));
      end
      case (r_state)
        c_IDLE: begin
          if (w_fire_rise) begin
            r_dx <= $signed({1'b0, hookX} - 12'(ANCHOR_X));
            r_dy <= $signed({1'b0, hookY} - 12'(ANCHOR_Y));
          end
        end
        c_EXTEND: begin
          if (grab) begin
            r_hit    <= 1'b1;
            r_weight <= grabWeight;
          end else if (startOfFrame && !w_stop) begin
            r_len <= w_next_len[9:0];
          end
        end
        c_RETRACT: begin
          if (startOfFrame) begin
            r_len <= w_done ? c_BASE_LEN : (r_len - w_step);
          end
        end
        default: begin
          r_hit <= 1'b0;
        end
      endcase
    end
  end

  assign tipX    = r_tip_x;
  assign tipY    = r_tip_y;
  assign ropeLen = r_len;

endmodule
`default_nettype wire

// File: tb/tb_hook_launcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_hook_launcher
// Purpose  : Vector-table bench with a catch scoreboard for hook_launcher
// Revision : 1.0  initial release
// ============================================================================
module tb_hook_launcher;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        fire = 1'b0;
  logic [10:0] hookX = 11'd300;
  logic [10:0] hookY = 11'd200;
  logic        grab = 1'b0;
  logic [1:0]  grabWeight = 2'd0;
  logic        hookEnable;
  logic [10:0] tipX;
  logic [10:0] tipY;
  logic [9:0]  ropeLen;
  logic        busy;
  logic        caught;
  logic [1:0]  caughtWeight;

  hook_launcher dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .fire         (fire),
    .hookX        (hookX),
    .hookY        (hookY),
    .grab         (grab),
    .grabWeight   (grabWeight),
    .hookEnable   (hookEnable),
    .tipX         (tipX),
    .tipY         (tipY),
    .ropeLen      (ropeLen),
    .busy         (busy),
    .caught       (caught),
    .caughtWeight (caughtWeight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hx, hy;
    int grab_len;   // 0 = no grab
    int grab_w;
    bit grab_sof;   // grab lands on the same cycle as startOfFrame
    bit toggle;     // toggle fire every frame while busy
    int peak, tx, ty;
    int rframes;
    bit exp_caught;
    int exp_w;
  } vec_t;

  typedef struct {
    bit caught;
    int w;
  } sb_t;

  sb_t  q[$];
  sb_t  e;
  int   checks = 0;
  int   errors = 0;
  int   c_cnt = 0;
  int   c_w = 0;
  bit   prev_busy = 1'b0;
  bit   toggle_en = 1'b0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every launch pushes its expected catch; popped when busy drops
  always @(posedge clk) begin
    #1;
    check("hookEnable_vs_busy", {31'd0, hookEnable}, {31'd0, ~busy});
    if (caught === 1'b1) begin
      c_cnt++;
      c_w = int'(caughtWeight);
    end
    if (prev_busy && !busy) begin
      if (q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = q.pop_front();
        check("caught_cycles", c_cnt, {31'd0, e.caught});
        if (e.caught) check("caught_weight", c_w, e.w);
      end
      c_cnt = 0;
    end
    prev_busy = busy;
  end

  task automatic frame(input bit with_grab);
    if (toggle_en) fire = ~fire;
    startOfFrame = 1'b1;
    grab = with_grab;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    grab = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic grab_only();
    grab = 1'b1;
    @(posedge clk); #1;
    grab = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic launch(input int hx, input int hy, input bit exp_c, input int exp_w);
    sb_t s;
    hookX = 11'(hx);
    hookY = 11'(hy);
    fire = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_tipX", tipX, hx);
    check("idle_tipY", tipY, hy);
    s.caught = exp_c;
    s.w = exp_w;
    q.push_back(s);
    fire = 1'b1;
    @(posedge clk); #1;
    check("launch_busy", busy, 1);
    check("launch_hookEnable", hookEnable, 0);
    // pendulum input keeps moving; the latched direction must be used
    hookX = 11'(hx) ^ 11'h055;
    hookY = 11'(hy) ^ 11'h033;
  endtask

  task automatic run_vec(input vec_t v);
    int prev;
    int fr;
    launch(v.hx, v.hy, v.exp_caught, v.exp_w);
    toggle_en = v.toggle;
    grabWeight = 2'(v.grab_w);
    fr = 0;
    while (fr < 120) begin
      if (v.grab_len != 0 && int'(ropeLen) == v.grab_len) begin
        if (v.grab_sof) frame(1'b1);
        else grab_only();
        break;
      end
      prev = int'(ropeLen);
      frame(1'b0);
      fr++;
      if (int'(ropeLen) == prev) break;
    end
    check("extend_bound", {31'd0, fr < 120}, 1);
    check("peak_len", ropeLen, v.peak);
    check("peak_tipX", tipX, v.tx);
    check("peak_tipY", tipY, v.ty);
    fr = 0;
    while (busy && fr < 200) begin
      frame(1'b0);
      fr++;
    end
    toggle_en = 1'b0;
    check("retract_frames", fr, v.rframes);
    check("return_len", ropeLen, 128);
    check("return_hookEnable", hookEnable, 1);
    if (fire) begin
      repeat (3) @(posedge clk);
      #1;
      check("held_fire_no_relaunch", busy, 0);
    end
    fire = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //           hx   hy  glen gw sof tog peak  tx   ty  rfr caught w
    vecs[0] = '{320, 224,   0, 0, 0, 0, 380, 320, 476, 32, 0, 0}; // straight miss
    vecs[1] = '{411, 187, 256, 0, 0, 0, 256, 502, 278, 16, 1, 0}; // diagonal
    vecs[2] = '{320, 224, 168, 2, 0, 1, 168, 320, 264, 20, 1, 2}; // weighted, fire toggling
    vecs[3] = '{320, 224, 380, 1, 1, 0, 380, 320, 476, 63, 1, 1}; // grab on boundary frame
    vecs[4] = '{229, 187,   0, 0, 0, 1, 400,  35, 380, 34, 0, 0}; // max length, negative dx
    vecs[5] = '{320, 224, 140, 3, 0, 0, 140, 320, 236, 12, 1, 3}; // heaviest, step 1

    #20;
    check("rst_ropeLen", ropeLen, 128);
    check("rst_tipX", tipX, 320);
    check("rst_tipY", tipY, 224);
    check("rst_hookEnable", hookEnable, 1);
    check("rst_busy", busy, 0);
    check("rst_caught", caught, 0);
    check("rst_caughtWeight", caughtWeight, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
    check("idle_track_x", tipX, 300);
    check("idle_track_y", tipY, 200);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // reset while reeling in a catch: no pulse, back to IDLE at once
    launch(320, 224, 1'b0, 0);
    repeat (5) frame(1'b0);
    grabWeight = 2'd3;
    grab_only();
    repeat (3) frame(1'b0);
    check("mid_len", ropeLen, 145);
    fire = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    check("midrst_len", ropeLen, 128);
    check("midrst_busy", busy, 0);
    check("midrst_hookEnable", hookEnable, 1);
    check("midrst_caught", caught, 0);
    check("midrst_tipY", tipY, 224);
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);
    check("post_rst_track", tipX, 320 ^ 'h055);
    check("sb_leftover", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
